// File: rtl/reservation_station_if.sv
// Dispatch / CDB / ALU issue bundle for the reservation station.
interface reservation_station_if #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = 4
);
  localparam int unsigned RS_W = $clog2(RS_SIZE);

  logic             ROB_clear;
  logic             Dis_flag;
  logic [5:0]       Dis_op;
  logic [31:0]      Dis_imm;
  logic [31:0]      Dis_PC;
  logic [4:0]       Dis_rd;
  logic [ROB_W-1:0] Dis_ROB_idx;
  logic             Dis_R1;
  logic             Dis_R2;
  logic [31:0]      Dis_V1;
  logic [31:0]      Dis_V2;
  logic             ALU_cdb_flag;
  logic [ROB_W-1:0] ALU_cdb_idx;
  logic [31:0]      ALU_cdb_val;
  logic             LSB_cdb_flag;
  logic [ROB_W-1:0] LSB_cdb_idx;
  logic [31:0]      LSB_cdb_val;
  logic [RS_W-1:0]  RS_put_idx;
  logic             RS_ready;
  logic [RS_W-1:0]  RS_ready_idx;
  logic             RS_full;
  logic             ALU_en;
  logic [5:0]       ALU_op;
  logic [31:0]      ALU_V1;
  logic [31:0]      ALU_V2;
  logic [31:0]      ALU_imm;
  logic [31:0]      ALU_PC;
  logic [ROB_W-1:0] ALU_ROB_idx;

  modport master (
    output ROB_clear, Dis_flag, Dis_op, Dis_imm, Dis_PC, Dis_rd, Dis_ROB_idx,
           Dis_R1, Dis_R2, Dis_V1, Dis_V2,
           ALU_cdb_flag, ALU_cdb_idx, ALU_cdb_val, LSB_cdb_flag, LSB_cdb_idx, LSB_cdb_val,
    input  RS_put_idx, RS_ready, RS_ready_idx, RS_full,
           ALU_en, ALU_op, ALU_V1, ALU_V2, ALU_imm, ALU_PC, ALU_ROB_idx
  );

  modport slave (
    input  ROB_clear, Dis_flag, Dis_op, Dis_imm, Dis_PC, Dis_rd, Dis_ROB_idx,
           Dis_R1, Dis_R2, Dis_V1, Dis_V2,
           ALU_cdb_flag, ALU_cdb_idx, ALU_cdb_val, LSB_cdb_flag, LSB_cdb_idx, LSB_cdb_val,
    output RS_put_idx, RS_ready, RS_ready_idx, RS_full,
           ALU_en, ALU_op, ALU_V1, ALU_V2, ALU_imm, ALU_PC, ALU_ROB_idx
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// snoops ALU/LSB broadcasts for wakeup, issues the lowest ready entry per cycle.
module reservation_station #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = 4
) (
  input logic                  clk_in,
  input logic                  rst_in,
  input logic                  rdy_in,
  reservation_station_if.slave bus
);
  localparam int unsigned RS_W  = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [5:0]         op_q  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic               r1_q  [RS_SIZE];
  logic               r2_q  [RS_SIZE];
  logic [31:0]        v1_q  [RS_SIZE];
  logic [31:0]        v2_q  [RS_SIZE];

  logic               alu_en_q;
  logic [5:0]         alu_op_q;
  logic [31:0]        alu_v1_q, alu_v2_q, alu_imm_q, alu_pc_q;
  logic [ROB_W-1:0]   alu_rob_q;

  logic [RS_W-1:0]    put_idx, ready_idx;
  logic               has_free, ready_any;
  logic [CNT_W-1:0]   free_cnt;

  // Returns {ready, value} after snooping both result buses; ALU wins a tie.
  function automatic logic [32:0] wake_op(input logic r, input logic [31:0] v,
                                          input logic af, input logic [ROB_W-1:0] ai,
                                          input logic [31:0] av, input logic lf,
                                          input logic [ROB_W-1:0] li, input logic [31:0] lv);
    wake_op = {r, v};
    if (!r) begin
      if (af && v[ROB_W-1:0] == ai) begin
        wake_op = {1'b1, av};
      end else if (lf && v[ROB_W-1:0] == li) begin
        wake_op = {1'b1, lv};
      end
    end
  endfunction

  // Lowest free slot, lowest ready slot and free count from registered state.
  always_comb begin
    put_idx   = '0;
    has_free  = 1'b0;
    ready_idx = '0;
    ready_any = 1'b0;
    free_cnt  = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        put_idx  = RS_W'(i);
        has_free = 1'b1;
      end
      if (busy_q[i] && r1_q[i] && r2_q[i]) begin
        ready_idx = RS_W'(i);
        ready_any = 1'b1;
      end
      free_cnt = free_cnt + CNT_W'(!busy_q[i]);
    end
  end

  // Busy next-state: issue frees a slot, dispatch claims the pre-edge free slot.
  always_comb begin
    busy_d = busy_q;
    if (ready_any) begin
      busy_d[ready_idx] = 1'b0;
    end
    if (bus.Dis_flag && has_free) begin
      busy_d[put_idx] = 1'b1;
    end
  end

  // Control state and issue register; flush and stall force ALU_en low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q    <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_v1_q  <= '0;
      alu_v2_q  <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_rob_q <= '0;
    end else if (!rdy_in) begin
      alu_en_q <= 1'b0;
    end else if (bus.ROB_clear) begin
      busy_q   <= '0;
      alu_en_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      alu_en_q <= ready_any;
      if (ready_any) begin
        alu_op_q  <= op_q[ready_idx];
        alu_v1_q  <= v1_q[ready_idx];
        alu_v2_q  <= v2_q[ready_idx];
        alu_imm_q <= imm_q[ready_idx];
        alu_pc_q  <= pc_q[ready_idx];
        alu_rob_q <= rob_q[ready_idx];
      end
    end
  end

  // Operand wakeup and dispatch write; payload is qualified by busy, so no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !bus.ROB_clear) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        {r1_q[i], v1_q[i]} <= wake_op(r1_q[i], v1_q[i], bus.ALU_cdb_flag, bus.ALU_cdb_idx,
                                      bus.ALU_cdb_val, bus.LSB_cdb_flag, bus.LSB_cdb_idx,
                                      bus.LSB_cdb_val);
        {r2_q[i], v2_q[i]} <= wake_op(r2_q[i], v2_q[i], bus.ALU_cdb_flag, bus.ALU_cdb_idx,
                                      bus.ALU_cdb_val, bus.LSB_cdb_flag, bus.LSB_cdb_idx,
                                      bus.LSB_cdb_val);
      end
      if (bus.Dis_flag && has_free) begin
        op_q[put_idx]  <= bus.Dis_op;
        imm_q[put_idx] <= bus.Dis_imm;
        pc_q[put_idx]  <= bus.Dis_PC;
        rob_q[put_idx] <= bus.Dis_ROB_idx;
        {r1_q[put_idx], v1_q[put_idx]} <= wake_op(bus.Dis_R1, bus.Dis_V1, bus.ALU_cdb_flag,
                                                  bus.ALU_cdb_idx, bus.ALU_cdb_val,
                                                  bus.LSB_cdb_flag, bus.LSB_cdb_idx,
                                                  bus.LSB_cdb_val);
        {r2_q[put_idx], v2_q[put_idx]} <= wake_op(bus.Dis_R2, bus.Dis_V2, bus.ALU_cdb_flag,
                                                  bus.ALU_cdb_idx, bus.ALU_cdb_val,
                                                  bus.LSB_cdb_flag, bus.LSB_cdb_idx,
                                                  bus.LSB_cdb_val);
      end
    end
  end

  // Dispatching into a station with no free slot is an upstream protocol error.
  dis_needs_free: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && !bus.ROB_clear && bus.Dis_flag) |-> has_free);

  assign bus.RS_put_idx   = put_idx;
  assign bus.RS_ready     = ready_any;
  assign bus.RS_ready_idx = ready_idx;
  assign bus.RS_full      = (free_cnt <= CNT_W'(1));
  assign bus.ALU_en       = alu_en_q;
  assign bus.ALU_op       = alu_op_q;
  assign bus.ALU_V1       = alu_v1_q;
  assign bus.ALU_V2       = alu_v2_q;
  assign bus.ALU_imm      = alu_imm_q;
  assign bus.ALU_PC       = alu_pc_q;
  assign bus.ALU_ROB_idx  = alu_rob_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a slot-level reference model.
module tb_reservation_station;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  reservation_station_if #(.RS_SIZE(16), .ROB_W(4)) bus ();

  reservation_station #(.RS_SIZE(16), .ROB_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of slots plus the issue register.
  typedef struct packed {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic        r1;
    logic [31:0] v1;
    logic        r2;
    logic [31:0] v2;
  } ent_t;

  ent_t        m_ent [16];
  logic        m_en;
  logic [5:0]  m_op;
  logic [31:0] m_v1, m_v2, m_imm, m_pc;
  logic [3:0]  m_rob;
  int          m_ri, m_fi;

  function automatic int m_first_free();
    for (int i = 0; i < 16; i++) if (!m_ent[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_first_ready();
    for (int i = 0; i < 16; i++) if (m_ent[i].busy && m_ent[i].r1 && m_ent[i].r2) return i;
    return -1;
  endfunction

  function automatic int m_free_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (!m_ent[i].busy) n++;
    return n;
  endfunction

  function automatic logic [32:0] m_wake(input logic r, input logic [31:0] v);
    if (r) return {r, v};
    if (bus.ALU_cdb_flag && v[3:0] == bus.ALU_cdb_idx) return {1'b1, bus.ALU_cdb_val};
    if (bus.LSB_cdb_flag && v[3:0] == bus.LSB_cdb_idx) return {1'b1, bus.LSB_cdb_val};
    return {r, v};
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 16; i++) m_ent[i].busy = 1'b0;
      m_en = 0; m_op = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
    end else if (!rdy_in) begin
      m_en = 1'b0;
    end else if (bus.ROB_clear) begin
      for (int i = 0; i < 16; i++) m_ent[i].busy = 1'b0;
      m_en = 1'b0;
    end else begin
      m_ri = m_first_ready();
      m_fi = m_first_free();
      m_en = (m_ri >= 0);
      if (m_ri >= 0) begin
        m_op  = m_ent[m_ri].op;
        m_v1  = m_ent[m_ri].v1;
        m_v2  = m_ent[m_ri].v2;
        m_imm = m_ent[m_ri].imm;
        m_pc  = m_ent[m_ri].pc;
        m_rob = m_ent[m_ri].rob;
        m_ent[m_ri].busy = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        if (m_ent[i].busy) begin
          {m_ent[i].r1, m_ent[i].v1} = m_wake(m_ent[i].r1, m_ent[i].v1);
          {m_ent[i].r2, m_ent[i].v2} = m_wake(m_ent[i].r2, m_ent[i].v2);
        end
      end
      if (bus.Dis_flag && m_fi >= 0) begin
        m_ent[m_fi].busy = 1'b1;
        m_ent[m_fi].op   = bus.Dis_op;
        m_ent[m_fi].imm  = bus.Dis_imm;
        m_ent[m_fi].pc   = bus.Dis_PC;
        m_ent[m_fi].rob  = bus.Dis_ROB_idx;
        {m_ent[m_fi].r1, m_ent[m_fi].v1} = m_wake(bus.Dis_R1, bus.Dis_V1);
        {m_ent[m_fi].r2, m_ent[m_fi].v2} = m_wake(bus.Dis_R2, bus.Dis_V2);
      end
    end
  end

  // Compare every settled cycle out of reset.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (m_first_free() >= 0) check("put_idx", 32'(bus.RS_put_idx), m_first_free());
      check("ready", 32'(bus.RS_ready), 32'(m_first_ready() >= 0));
      if (m_first_ready() >= 0) check("ready_idx", 32'(bus.RS_ready_idx), m_first_ready());
      check("full", 32'(bus.RS_full), 32'(m_free_count() <= 1));
      check("alu_en", 32'(bus.ALU_en), 32'(m_en));
      check("alu_op", 32'(bus.ALU_op), 32'(m_op));
      check("alu_v1", bus.ALU_V1, m_v1);
      check("alu_v2", bus.ALU_V2, m_v2);
      check("alu_imm", bus.ALU_imm, m_imm);
      check("alu_pc", bus.ALU_PC, m_pc);
      check("alu_rob", 32'(bus.ALU_ROB_idx), 32'(m_rob));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.Dis_flag     = 1'b0;
    bus.ROB_clear    = 1'b0;
    bus.ALU_cdb_flag = 1'b0;
    bus.LSB_cdb_flag = 1'b0;
  endtask

  task automatic dis(input logic [5:0] op, input logic r1, input logic [31:0] v1,
                     input logic r2, input logic [31:0] v2, input logic [3:0] rob);
    bus.Dis_flag    = 1'b1;
    bus.Dis_op      = op;
    bus.Dis_R1      = r1;
    bus.Dis_V1      = v1;
    bus.Dis_R2      = r2;
    bus.Dis_V2      = v2;
    bus.Dis_ROB_idx = rob;
    bus.Dis_rd      = 5'(rob);
    bus.Dis_imm     = 32'h100 + 32'(rob);
    bus.Dis_PC      = 32'h1000 + 32'(rob) * 4;
  endtask

  logic [3:0] t6_tags [5];

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b0;
    idle();
    bus.Dis_op = '0; bus.Dis_imm = '0; bus.Dis_PC = '0; bus.Dis_rd = '0;
    bus.Dis_ROB_idx = '0; bus.Dis_R1 = 1'b0; bus.Dis_R2 = 1'b0;
    bus.Dis_V1 = '0; bus.Dis_V2 = '0;
    bus.ALU_cdb_idx = '0; bus.ALU_cdb_val = '0; bus.LSB_cdb_idx = '0; bus.LSB_cdb_val = '0;
    #2 rst_in = 1'b1;
    #10 rst_in = 1'b0;
    rdy_in = 1'b1;
    tick();

    // Ready-at-dispatch ADD, with one stalled cycle before issue.
    dis(6'h01, 1'b1, 32'd5, 1'b1, 32'd7, 4'd3);
    tick(); idle();
    check("t2_en_before", 32'(bus.ALU_en), 0);
    check("t2_ready", 32'(bus.RS_ready), 1);
    rdy_in = 1'b0;
    tick();
    rdy_in = 1'b1;
    check("t2_stall_en", 32'(bus.ALU_en), 0);
    check("t2_stall_ready", 32'(bus.RS_ready), 1);
    tick();
    check("t2_en", 32'(bus.ALU_en), 1);
    check("t2_v1", bus.ALU_V1, 32'd5);
    check("t2_v2", bus.ALU_V2, 32'd7);
    check("t2_rob", 32'(bus.ALU_ROB_idx), 3);

    // V1 waits on tag 2, woken by the ALU bus one cycle later.
    dis(6'h02, 1'b0, 32'd2, 1'b1, 32'd1, 4'd5);
    tick(); idle();
    check("t3_not_ready", 32'(bus.RS_ready), 0);
    bus.ALU_cdb_flag = 1'b1; bus.ALU_cdb_idx = 4'd2; bus.ALU_cdb_val = 32'hDEAD;
    tick(); idle();
    check("t3_ready", 32'(bus.RS_ready), 1);
    tick();
    check("t3_en", 32'(bus.ALU_en), 1);
    check("t3_v1", bus.ALU_V1, 32'hDEAD);
    check("t3_rob", 32'(bus.ALU_ROB_idx), 5);

    // LSB broadcast coincides with dispatch of the consumer.
    dis(6'h03, 1'b1, 32'd3, 1'b0, 32'd6, 4'd6);
    bus.LSB_cdb_flag = 1'b1; bus.LSB_cdb_idx = 4'd6; bus.LSB_cdb_val = 32'd9;
    tick(); idle();
    check("t4_ready", 32'(bus.RS_ready), 1);
    tick();
    check("t4_en", 32'(bus.ALU_en), 1);
    check("t4_v2", bus.ALU_V2, 32'd9);

    // Asynchronous reset with three waiting entries.
    for (int k = 0; k < 3; k++) begin
      dis(6'h04, 1'b0, 32'(10 + k), 1'b1, 32'd0, 4'(k));
      tick();
    end
    idle();
    check("t1_put_before", 32'(bus.RS_put_idx), 3);
    #2 rst_in = 1'b1;
    #1;
    check("t1_put", 32'(bus.RS_put_idx), 0);
    check("t1_ready", 32'(bus.RS_ready), 0);
    check("t1_full", 32'(bus.RS_full), 0);
    check("t1_en", 32'(bus.ALU_en), 0);
    check("t1_v2", bus.ALU_V2, 0);
    check("t1_op", 32'(bus.ALU_op), 0);
    #2 rst_in = 1'b0;
    tick();

    // Fill to the stall threshold, then flush.
    for (int k = 0; k < 15; k++) begin
      dis(6'h05, 1'b0, 32'd8, 1'b0, 32'd8, 4'(k));
      tick();
      if (k == 13) check("t5_not_full", 32'(bus.RS_full), 0);
    end
    idle();
    check("t5_full", 32'(bus.RS_full), 1);
    check("t5_put", 32'(bus.RS_put_idx), 15);
    bus.ROB_clear = 1'b1;
    bus.ALU_cdb_flag = 1'b1; bus.ALU_cdb_idx = 4'd8; bus.ALU_cdb_val = 32'h77;
    tick(); idle();
    check("t5_clr_full", 32'(bus.RS_full), 0);
    check("t5_clr_put", 32'(bus.RS_put_idx), 0);
    check("t5_clr_ready", 32'(bus.RS_ready), 0);
    tick();
    check("t5_no_issue", 32'(bus.ALU_en), 0);

    // Slots 1 and 4 wake together; lowest issues first while dispatch continues.
    t6_tags[0] = 4'd9; t6_tags[1] = 4'd5; t6_tags[2] = 4'd9; t6_tags[3] = 4'd9;
    t6_tags[4] = 4'd5;
    for (int k = 0; k < 5; k++) begin
      dis(6'h06, 1'b0, 32'(t6_tags[k]), 1'b1, 32'(k), 4'(k));
      tick();
    end
    idle();
    bus.ALU_cdb_flag = 1'b1; bus.ALU_cdb_idx = 4'd5; bus.ALU_cdb_val = 32'h55;
    tick(); idle();
    check("t6_ready_idx", 32'(bus.RS_ready_idx), 1);
    check("t6_put", 32'(bus.RS_put_idx), 5);
    dis(6'h07, 1'b0, 32'd9, 1'b1, 32'd0, 4'd7);
    tick(); idle();
    check("t6_en1", 32'(bus.ALU_en), 1);
    check("t6_rob1", 32'(bus.ALU_ROB_idx), 1);
    check("t6_v1", bus.ALU_V1, 32'h55);
    check("t6_put_after", 32'(bus.RS_put_idx), 1);
    check("t6_ready_idx2", 32'(bus.RS_ready_idx), 4);
    tick();
    check("t6_en2", 32'(bus.ALU_en), 1);
    check("t6_rob2", 32'(bus.ALU_ROB_idx), 4);
    check("t6_v2", bus.ALU_V2, 32'd4);
    check("t6_none_ready", 32'(bus.RS_ready), 0);
    tick();
    check("t6_en_off", 32'(bus.ALU_en), 0);

    bus.ROB_clear = 1'b1;
    tick(); idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
